// File: rtl/fp_norm_round_if.sv
// Handshake bundle for fp_norm_round: operand port (in_*) and result port (out_*).
// master drives operands and out_ready; slave is the normalizer.
interface fp_norm_round_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sign;
    logic [EXP_W-1:0]          in_exp;
    logic [FRAC_W+1:0]         in_mant;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W+FRAC_W:0]     out_result;
    logic                      out_zero;
    logic                      out_ovf;
    logic                      out_udf;
    logic                      out_inexact;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_zero, out_ovf, out_udf, out_inexact
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result,
        output out_zero, out_ovf, out_udf, out_inexact
    );
endinterface

// File: rtl/fp_norm_round.sv
// Iterative normalizer/rounder/packer: one shift per cycle, valid/ready on both ports.
// Ports: clk, rst_n (async low), bus (fp_norm_round_if.slave). Macro FP_NORM_RNE_EN selects RNE.
module fp_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic clk,
    input  logic rst_n,
    fp_norm_round_if.slave bus
);
    localparam int MW = FRAC_W + 2;
    localparam int EW = EXP_W + 2;
    localparam int RW = 1 + EXP_W + FRAC_W;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, NORM, RND, OUT} state_t;

    state_t          state, state_n;
    logic            sign, sign_n;
    logic [EW-1:0]   e, e_n;
    logic [MW-1:0]   m, m_n;
    logic            g, g_n;
    logic [RW-1:0]   res, res_n;
    logic            zero, zero_n;
    logic            ovf, ovf_n;
    logic            udf, udf_n;
    logic            inx, inx_n;

    // Rounded significand; a carry out of it is folded into the packed fraction.
    logic [MW-1:0]     mr;
    logic [EW-1:0]     er;
    logic [FRAC_W-1:0] fr;

    always_comb begin
        mr = m;
`ifdef FP_NORM_RNE_EN
        // One discarded bit: G=1 is always a tie, so round up only if odd.
        mr = m + MW'(g & m[0]);
`endif
        er = e;
        fr = mr[FRAC_W-1:0];
        if (mr[MW-1]) begin
            er = e + EW'(1);
            fr = mr[FRAC_W:1];
        end
    end

    always_comb begin
        state_n = state;
        sign_n  = sign;
        e_n     = e;
        m_n     = m;
        g_n     = g;
        res_n   = res;
        zero_n  = zero;
        ovf_n   = ovf;
        udf_n   = udf;
        inx_n   = inx;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_n = bus.in_sign;
                    e_n    = EW'(bus.in_exp);
                    m_n    = bus.in_mant;
                    g_n    = 1'b0;
                    if (bus.in_mant == '0) begin
                        res_n   = {bus.in_sign, {(RW-1){1'b0}}};
                        zero_n  = 1'b1;
                        ovf_n   = 1'b0;
                        udf_n   = 1'b0;
                        inx_n   = 1'b0;
                        state_n = OUT;
                    end else begin
                        state_n = NORM;
                    end
                end
            end
            NORM: begin
                if (m[MW-1]) begin
                    m_n     = m >> 1;
                    g_n     = m[0];
                    e_n     = e + EW'(1);
                    state_n = RND;
                end else if (m[FRAC_W]) begin
                    state_n = RND;
                end else if (e <= EW'(1)) begin
                    res_n   = {sign, {(RW-1){1'b0}}};
                    zero_n  = 1'b0;
                    ovf_n   = 1'b0;
                    udf_n   = 1'b1;
                    inx_n   = 1'b1;
                    state_n = OUT;
                end else begin
                    m_n = m << 1;
                    e_n = e - EW'(1);
                end
            end
            RND: begin
                zero_n = 1'b0;
                ovf_n  = 1'b0;
                udf_n  = 1'b0;
                inx_n  = g;
                if (er == '0) begin
                    res_n = {sign, {(RW-1){1'b0}}};
                    udf_n = 1'b1;
                end else if (er >= EMAX) begin
                    res_n = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    ovf_n = 1'b1;
                end else begin
                    res_n = {sign, er[EXP_W-1:0], fr};
                end
                state_n = OUT;
            end
            OUT: begin
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sign  <= 1'b0;
            e     <= '0;
            m     <= '0;
            g     <= 1'b0;
            res   <= '0;
            zero  <= 1'b0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
            inx   <= 1'b0;
        end else begin
            state <= state_n;
            sign  <= sign_n;
            e     <= e_n;
            m     <= m_n;
            g     <= g_n;
            res   <= res_n;
            zero  <= zero_n;
            ovf   <= ovf_n;
            udf   <= udf_n;
            inx   <= inx_n;
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == OUT);
    assign bus.out_result  = res;
    assign bus.out_zero    = zero;
    assign bus.out_ovf     = ovf;
    assign bus.out_udf     = udf;
    assign bus.out_inexact = inx;
endmodule
